alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execution sequencer directly upstream of the 32-bit ALU: owns a 32x32 register file, accepts one
//  command per handshake, drives the ALU operands/opcode, captures F/ZF/OF, writes the result back.
//  Sits between the instruction/command source and the combinational ALU; the ALU sits outside.
// PARAMETERS
//  DATA_W  32  operand/result width (must match the ALU)
//  ADDR_W  5   register address width; 2**ADDR_W registers, register 0 hardwired to zero
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready (high only in IDLE)
//  cmd_op     in   3       ALU opcode: 000 and,001 or,010 xor,011 xnor,100 add,101 sub,110 A<B,111 B<<A
//  cmd_ra     in   ADDR_W  source register for ALU operand A
//  cmd_rb     in   ADDR_W  source register for ALU operand B (ignored when cmd_li=1)
//  cmd_li     in   1       1: operand B = cmd_imm instead of register rb
//  cmd_imm    in   DATA_W  immediate operand B
//  cmd_rw     in   ADDR_W  destination register
//  cmd_wb     in   1       1: write result to cmd_rw
//  alu_a      out  DATA_W  to ALU A
//  alu_b      out  DATA_W  to ALU B
//  alu_op     out  3       to ALU ALU_OP
//  alu_f      in   DATA_W  from ALU F
//  alu_zf     in   1       from ALU ZF
//  alu_of     in   1       from ALU OF
//  done       out  1       one-cycle pulse: result/flags valid, write-back occurring this cycle
//  result     out  DATA_W  last captured ALU result (held until next capture)
//  flag_zf    out  1       last captured zero flag
//  flag_of    out  1       last captured overflow flag (0 for non add/sub ops)
//  dbg_addr   in   ADDR_W  debug read address
//  dbg_data   out  DATA_W  combinational read of register dbg_addr (0 for address 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all registers incl. register file = 0; alu_a/alu_b/alu_op,
//   result, flag_zf, flag_of, done = 0; cmd_ready = 1 after release.
//  FSM IDLE -> EXEC -> WB -> IDLE, one step per clock; no stalls; cmd_ready = (state==IDLE).
//  IDLE: on accept at edge N, latch alu_a=reg[ra], alu_b=cmd_li?cmd_imm:reg[rb], alu_op=cmd_op,
//   rw, wb into command registers; go EXEC. cmd_valid with cmd_ready=0 is ignored (not queued).
//  EXEC (cycle N+1): ALU operands stable from registers; at edge capture result=alu_f, flag_zf=alu_zf,
//   flag_of = alu_of if op in {100,101} else 0 (ALU OF is stale for other ops); go WB.
//  WB (cycle N+2): done=1; if wb && rw!=0, reg[rw]=result at the closing edge; go IDLE.
//  Latency: done high exactly 2 cycles after accept edge; throughput 1 command per 3 cycles.
//  Back-to-back: command accepted at N+3 reads the value written in WB (no hazard, no bypass needed).
//  Writes to register 0 are discarded; reads of register 0 return 0 (operands and dbg_data).
//  alu_a/alu_b/alu_op hold their last values in IDLE and WB; result/flags hold until next EXEC.
//  All arithmetic done by the external ALU; this block performs no width extension or truncation.
//  Reset mid-operation: returns to IDLE immediately, no done pulse, no write-back of the pending command.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all outputs 0 immediately; after release cmd_ready=1, dbg_data(any)=0.
//  2 Load r1: op=100,ra=0,li=1,imm=0x7FFFFFFF,rw=1,wb=1 -> done 2 cycles after accept, dbg r1=0x7FFFFFFF;
//    load r2=1; then add ra=1,rb=2,rw=3 -> result=0x80000000, flag_of=1, flag_zf=0, r3=0x80000000.
//  3 Sub r2-r2 -> result=0, flag_zf=1, flag_of=0; then xor r1,r1 after an overflow -> flag_of=0.
//  4 Shift: load r5=4; op=111,ra=5,li=1,imm=1 -> result=0x10; op=110,ra=2,li=1,imm=5 -> result=1.
//  5 rw=0,wb=1 with result 0x1234 -> dbg r0=0; cmd_valid held during EXEC/WB -> cmd_ready=0, no second
//    accept; back-to-back add reading previous rw gets the written value.
//  6 rst_n=0 during EXEC of add to r6 -> done never pulses, r6=0, state IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Command handshake bundle between the instruction source and the ALU execution sequencer.
interface alu_exec_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic              cmd_li;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] cmd_rw;
    logic              cmd_wb;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_li, cmd_imm, cmd_rw, cmd_wb,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_li, cmd_imm, cmd_rw, cmd_wb,
        output cmd_ready
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execution sequencer in front of an external combinational ALU: register file, operand
// staging, flag capture and result write-back, one command every three cycles.
module alu_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_ctrl_if.slave    cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zf,
    output logic              flag_of,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [2:0]        alu_op_q;
    logic [ADDR_W-1:0] rw_q;
    logic              wb_q;
    logic [DATA_W-1:0] result_q;
    logic              zf_q, of_q;
    logic              accept;
    logic [DATA_W-1:0] opA, opB;

    assign accept = cmd.cmd_valid && (state_q == IDLE);

    assign opA = (cmd.cmd_ra == '0) ? '0 : regs_q[cmd.cmd_ra];
    assign opB = cmd.cmd_li ? cmd.cmd_imm
               : ((cmd.cmd_rb == '0) ? '0 : regs_q[cmd.cmd_rb]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ALU reports a raw adder overflow for every opcode; only add/sub may keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rw_q     <= '0;
            wb_q     <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_a_q  <= opA;
                alu_b_q  <= opB;
                alu_op_q <= cmd.cmd_op;
                rw_q     <= cmd.cmd_rw;
                wb_q     <= cmd.cmd_wb;
            end
            if (state_q == EXEC) begin
                result_q <= alu_f;
                zf_q     <= alu_zf;
                of_q     <= (alu_op_q[2:1] == 2'b10) ? alu_of : 1'b0;
            end
            if ((state_q == WB) && wb_q && (rw_q != '0)) begin
                regs_q[rw_q] <= result_q;
            end
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign done          = (state_q == WB);
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign result        = result_q;
    assign flag_zf       = zf_q;
    assign flag_of       = of_q;
    assign dbg_data      = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Table-driven bench for alu_exec_ctrl with a behavioural 32-bit ALU closing the loop.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_op;
    logic        alu_zf, alu_of;
    logic        done, flag_zf, flag_of;
    logic [31:0] result, dbg_data;
    logic [4:0]  dbgAddr;
    int          total;
    int          bad;

    alu_exec_ctrl_if #(.DATA_W(32), .ADDR_W(5)) cmdIf ();

    alu_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmdIf),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_f    (alu_f),
        .alu_zf   (alu_zf),
        .alu_of   (alu_of),
        .done     (done),
        .result   (result),
        .flag_zf  (flag_zf),
        .flag_of  (flag_of),
        .dbg_addr (dbgAddr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: OF is the raw adder (or subtractor) overflow regardless of opcode.
    always_comb begin
        logic [31:0] sum, diff;
        sum    = alu_a + alu_b;
        diff   = alu_a - alu_b;
        alu_f  = '0;
        case (alu_op)
            3'b000: alu_f = alu_a & alu_b;
            3'b001: alu_f = alu_a | alu_b;
            3'b010: alu_f = alu_a ^ alu_b;
            3'b011: alu_f = ~(alu_a ^ alu_b);
            3'b100: alu_f = sum;
            3'b101: alu_f = diff;
            3'b110: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_f = alu_b << alu_a[4:0];
        endcase
        alu_zf = (alu_f == 32'd0);
        if (alu_op == 3'b101) alu_of = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
        else                  alu_of = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    end

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        li;
        logic [31:0] imm;
        logic [4:0]  rw;
        logic        wb;
        logic [31:0] expRes;
        logic        expZf;
        logic        expOf;
        logic [31:0] expDbg;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mkVec(logic [2:0] op, logic [4:0] ra, logic [4:0] rb, logic li,
                                   logic [31:0] imm, logic [4:0] rw, logic wb,
                                   logic [31:0] expRes, logic expZf, logic expOf,
                                   logic [31:0] expDbg);
        vec_t v;
        v.op = op; v.ra = ra; v.rb = rb; v.li = li; v.imm = imm; v.rw = rw; v.wb = wb;
        v.expRes = expRes; v.expZf = expZf; v.expOf = expOf; v.expDbg = expDbg;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveCmd(input vec_t v);
        cmdIf.cmd_op    = v.op;
        cmdIf.cmd_ra    = v.ra;
        cmdIf.cmd_rb    = v.rb;
        cmdIf.cmd_li    = v.li;
        cmdIf.cmd_imm   = v.imm;
        cmdIf.cmd_rw    = v.rw;
        cmdIf.cmd_wb    = v.wb;
        cmdIf.cmd_valid = 1'b1;
    endtask

    task automatic checkDbg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        @(negedge clk);
        dbgAddr = addr;
        #1;
        checkOutput(name, dbg_data, exp);
    endtask

    // Drives at the first idle falling edge; done must rise exactly two edges after accept.
    task automatic applyStimulus(input vec_t v, input int idx);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmdIf.cmd_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!cmdIf.cmd_ready) begin
            bad++;
            total++;
            $display("[TB] FAIL v%0d_ready_timeout: got 0 expected 1", idx);
        end
        driveCmd(v);
        @(posedge clk); #1;
        cmdIf.cmd_valid = 1'b0;
        checkOutput($sformatf("v%0d_exec_done", idx), {31'd0, done}, 32'd0);
        checkOutput($sformatf("v%0d_exec_ready", idx), {31'd0, cmdIf.cmd_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_wb_done", idx), {31'd0, done}, 32'd1);
        checkOutput($sformatf("v%0d_result", idx), result, v.expRes);
        checkOutput($sformatf("v%0d_zf", idx), {31'd0, flag_zf}, {31'd0, v.expZf});
        checkOutput($sformatf("v%0d_of", idx), {31'd0, flag_of}, {31'd0, v.expOf});
        dbgAddr = v.rw;
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_idle_done", idx), {31'd0, done}, 32'd0);
        checkOutput($sformatf("v%0d_dbg", idx), dbg_data, v.expDbg);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawDone;
        vec_t heldCmd;
        total = 0;
        bad   = 0;

        vecs[0]  = mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h7FFF_FFFF, 5'd1,  1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF);
        vecs[1]  = mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h0000_0001, 5'd2,  1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001);
        vecs[2]  = mkVec(3'b100, 5'd1, 5'd2, 1'b0, 32'h0000_0000, 5'd3,  1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000);
        vecs[3]  = mkVec(3'b101, 5'd2, 5'd2, 1'b0, 32'h0000_0000, 5'd4,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
        vecs[4]  = mkVec(3'b100, 5'd1, 5'd1, 1'b0, 32'h0000_0000, 5'd7,  1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0000_0000);
        vecs[5]  = mkVec(3'b010, 5'd1, 5'd1, 1'b0, 32'h0000_0000, 5'd4,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
        vecs[6]  = mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h0000_0004, 5'd5,  1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004);
        vecs[7]  = mkVec(3'b111, 5'd5, 5'd0, 1'b1, 32'h0000_0001, 5'd6,  1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010);
        vecs[8]  = mkVec(3'b110, 5'd2, 5'd0, 1'b1, 32'h0000_0005, 5'd8,  1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001);
        vecs[9]  = mkVec(3'b000, 5'd1, 5'd0, 1'b1, 32'hFFFF_0000, 5'd9,  1'b1, 32'h7FFF_0000, 1'b0, 1'b0, 32'h7FFF_0000);
        vecs[10] = mkVec(3'b001, 5'd2, 5'd0, 1'b1, 32'h0000_0100, 5'd10, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 32'h0000_0101);
        vecs[11] = mkVec(3'b011, 5'd0, 5'd0, 1'b1, 32'h0000_0000, 5'd11, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
        vecs[12] = mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h0000_1234, 5'd0,  1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_0000);

        rst_n           = 1'b0;
        dbgAddr         = '0;
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_op    = '0;
        cmdIf.cmd_ra    = '0;
        cmdIf.cmd_rb    = '0;
        cmdIf.cmd_li    = 1'b0;
        cmdIf.cmd_imm   = '0;
        cmdIf.cmd_rw    = '0;
        cmdIf.cmd_wb    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready",  {31'd0, cmdIf.cmd_ready}, 32'd1);
        checkOutput("rst_done",   {31'd0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
        checkDbg("rst_dbg_r1",  5'd1,  32'd0);
        checkDbg("rst_dbg_r31", 5'd31, 32'd0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Accepted immediately after the previous write-back: must see r6 = 0x10.
        applyStimulus(mkVec(3'b100, 5'd6, 5'd6, 1'b0, 32'h0, 5'd6, 1'b1,
                            32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020), 13);
        checkDbg("r3_after", 5'd3, 32'h8000_0000);

        heldCmd = mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h0000_0042, 5'd12, 1'b1,
                        32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        driveCmd(heldCmd);
        @(posedge clk); #1;
        checkOutput("held_exec_ready", {31'd0, cmdIf.cmd_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("held_wb_ready",  {31'd0, cmdIf.cmd_ready}, 32'd0);
        checkOutput("held_wb_done",   {31'd0, done}, 32'd1);
        checkOutput("held_result",    result, 32'h0000_0042);
        cmdIf.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("held_idle_ready", {31'd0, cmdIf.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("held_no_second",  {31'd0, cmdIf.cmd_ready}, 32'd1);
        checkOutput("held_no_done",    {31'd0, done}, 32'd0);
        checkDbg("held_dbg_r12", 5'd12, 32'h0000_0042);

        dbgAddr = 5'd1;
        @(negedge clk);
        driveCmd(mkVec(3'b100, 5'd0, 5'd0, 1'b1, 32'h0000_0055, 5'd6, 1'b1,
                       32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge clk); #1;
        cmdIf.cmd_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_done",   {31'd0, done}, 32'd0);
        checkOutput("mid_rst_ready",  {31'd0, cmdIf.cmd_ready}, 32'd1);
        checkOutput("mid_rst_result", result, 32'd0);
        checkOutput("mid_rst_alu_a",  alu_a, 32'd0);
        checkOutput("mid_rst_alu_b",  alu_b, 32'd0);
        checkOutput("mid_rst_alu_op", {29'd0, alu_op}, 32'd0);
        checkOutput("mid_rst_flags",  {30'd0, flag_zf, flag_of}, 32'd0);
        checkOutput("mid_rst_dbg_r1", dbg_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("mid_rst_no_done", {31'd0, sawDone}, 32'd0);
        checkOutput("mid_rst_ready2",  {31'd0, cmdIf.cmd_ready}, 32'd1);
        checkDbg("mid_rst_dbg_r6", 5'd6, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
